// File: rtl/nemesis_peek_pkg.sv
// Shared types and helpers for the runtime SDRAM peek unit.
package nemesis_peek_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } peek_state_t;

    localparam logic [7:0] TIMEOUT_BYTE = 8'hEE;

    // Big-endian slots keep the even byte in the upper half of the word.
    function automatic logic [7:0] byte_pick(
        input logic [15:0] data,
        input logic        lane,
        input logic        be,
        input int          dw
    );
        logic [7:0] r;
        if (dw == 8)
            r = data[7:0];
        else if (be)
            r = lane ? data[7:0] : data[15:8];
        else
            r = lane ? data[15:8] : data[7:0];
        return r;
    endfunction

endpackage

// File: rtl/nemesis_peek_mux.sv
// Per-slot override mux: either the peek request or the requester owns the slot.
import nemesis_peek_pkg::*;

module nemesis_peek_mux #(
    parameter int AW = 17
) (
    input  logic          i_ovr,
    input  logic          i_peek_cs,
    input  logic [AW-1:0] i_peek_addr,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    input  logic          i_ok,
    output logic          o_cs,
    output logic [AW-1:0] o_addr,
    output logic          o_ok
);

    always_comb begin
        o_cs   = i_cs;
        o_addr = i_addr;
        o_ok   = i_ok;
        if (i_ovr) begin
            o_cs   = i_peek_cs;
            o_addr = i_peek_addr;
            o_ok   = 1'b0;
        end
    end

endmodule

// File: rtl/nemesis_rom_peek.sv
// Debug peek unit: hijacks one SDRAM slot to fetch a byte at a debug address.
import nemesis_peek_pkg::*;

module nemesis_rom_peek #(
    parameter int                    CHANNELS = 2,
    parameter int                    AW       = 17,
    parameter int                    DW       = 16,
    parameter logic [CHANNELS-1:0]   BE_MASK  = 2'b10,
    parameter int                    TIMEOUT  = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cen,
    input  logic                   i_enable,
    input  logic [2:0]             i_sel,
    input  logic [AW:0]            i_debug_addr,
    input  logic [CHANNELS-1:0]    i_cs,
    input  logic [CHANNELS*AW-1:0] i_addr,
    output logic [CHANNELS-1:0]    o_cs,
    output logic [CHANNELS*AW-1:0] o_addr,
    input  logic [CHANNELS-1:0]    i_ok,
    input  logic [CHANNELS*DW-1:0] i_data,
    output logic [CHANNELS-1:0]    o_ok,
    output logic [7:0]             o_debug_view,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int             CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    peek_state_t   state_q, state_d;
    logic [2:0]    sel_q, sel_d, prev_sel_q, prev_sel_d;
    logic [AW:0]   addr_q, addr_d, prev_addr_q, prev_addr_d;
    logic          prev_en_q, prev_en_d;
    logic          pending_q, pending_d;
    logic          ovr_q, ovr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    view_q, view_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic          trig, sel_valid, start;
    logic          ok_sel, be_sel;
    logic [15:0]   data_sel;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] peek_addr;

    if (DW == 16) begin : g_w16
        assign peek_addr = addr_q[AW:1];
    end else begin : g_w8
        assign peek_addr = addr_q[AW-1:0];
    end

    always_comb begin
        ok_sel   = 1'b0;
        be_sel   = 1'b0;
        data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_q == 3'(k)) begin
                ok_sel   = i_ok[k];
                be_sel   = BE_MASK[k];
                data_sel = 16'(i_data[k*DW +: DW]);
            end
        end
    end

    assign sel_valid = ({1'b0, i_sel} < 4'(CHANNELS));
    assign trig      = i_enable && (!prev_en_q ||
                       i_debug_addr != prev_addr_q ||
                       i_sel != prev_sel_q);
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        prev_sel_d  = prev_sel_q;
        prev_addr_d = prev_addr_q;
        prev_en_d   = prev_en_q;
        pending_d   = pending_q;
        ovr_d       = ovr_q;
        cnt_d       = cnt_q;
        view_d      = view_q;
        busy_d      = busy_q;
        timeout_d   = timeout_q;
        start       = 1'b0;
        if (i_cen) begin
            prev_sel_d  = i_sel;
            prev_addr_d = i_debug_addr;
            prev_en_d   = i_enable;
            unique case (state_q)
                IDLE: start = trig && sel_valid;
                REQ: begin
                    if (trig)
                        pending_d = 1'b1;
                    if (!i_enable)
                        pending_d = 1'b0;
                    if (ok_sel) begin
                        view_d  = byte_pick(data_sel, addr_q[0], be_sel, DW);
                        ovr_d   = 1'b0;
                        state_d = DONE;
                    end else if (cnt_inc == TMO) begin
                        view_d    = TIMEOUT_BYTE;
                        timeout_d = 1'b1;
                        ovr_d     = 1'b0;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DONE: begin
                    // Slot is back with its owner for this cycle so a late ok drains.
                    pending_d = 1'b0;
                    start     = (pending_q || trig) && i_enable && sel_valid;
                    if (!start) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start) begin
                sel_d     = i_sel;
                addr_d    = i_debug_addr;
                cnt_d     = '0;
                timeout_d = 1'b0;
                busy_d    = 1'b1;
                ovr_d     = 1'b1;
                state_d   = REQ;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            prev_sel_q  <= '0;
            prev_addr_q <= '0;
            prev_en_q   <= 1'b0;
            pending_q   <= 1'b0;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
            view_q      <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            prev_sel_q  <= prev_sel_d;
            prev_addr_q <= prev_addr_d;
            prev_en_q   <= prev_en_d;
            pending_q   <= pending_d;
            ovr_q       <= ovr_d;
            cnt_q       <= cnt_d;
            view_q      <= view_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        nemesis_peek_mux #(.AW(AW)) u_mux (
            .i_ovr       (ovr_q && (sel_q == 3'(k))),
            .i_peek_cs   (ovr_q),
            .i_peek_addr (peek_addr),
            .i_cs        (i_cs[k]),
            .i_addr      (i_addr[k*AW +: AW]),
            .i_ok        (i_ok[k]),
            .o_cs        (o_cs[k]),
            .o_addr      (o_addr[k*AW +: AW]),
            .o_ok        (o_ok[k])
        );
    end

    assign o_debug_view = view_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_nemesis_rom_peek.sv
// Directed bench for the SDRAM peek unit (2 slots, 16-bit, slot 1 big-endian).
module tb_nemesis_rom_peek;

    localparam int CH = 2;
    localparam int AW = 17;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cen;
    logic            en;
    logic [2:0]      sel;
    logic [AW:0]     daddr;
    logic [CH-1:0]   cs_i, cs_o, ok_i, ok_o;
    logic [CH*AW-1:0] addr_i, addr_o;
    logic [CH*DW-1:0] data_i;
    logic [7:0]      view;
    logic            busy, tmo;

    int checks = 0;
    int failures = 0;

    nemesis_rom_peek #(
        .CHANNELS(CH), .AW(AW), .DW(DW),
        .BE_MASK(2'b10), .TIMEOUT(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cen(cen),
        .i_enable(en), .i_sel(sel), .i_debug_addr(daddr),
        .i_cs(cs_i), .i_addr(addr_i), .o_cs(cs_o), .o_addr(addr_o),
        .i_ok(ok_i), .i_data(data_i), .o_ok(ok_o),
        .o_debug_view(view), .o_busy(busy), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; en = 1'b0; sel = 3'd0; daddr = '0;
        cs_i = 2'b01; ok_i = 2'b10; addr_i = {17'h00AAA, 17'h00555};
        data_i = '0;
        #12;
        checks++; if (view !== 8'h00) begin failures++;
            $display("FAIL rst_view got=%0h exp=0", view); end
        checks++; if (busy !== 1'b0 || tmo !== 1'b0) begin failures++;
            $display("FAIL rst_flags got=%0b%0b exp=00", busy, tmo); end
        checks++; if (cs_o !== 2'b01 || ok_o !== 2'b10 || addr_o !== addr_i) begin failures++;
            $display("FAIL rst_pass got=%0b/%0b exp=01/10", cs_o, ok_o); end
        rst = 1'b0;
        cs_i = '0; ok_i = '0; addr_i = '0;
        tick();
    endtask

    task automatic test_be_slot();
        en = 1'b1; sel = 3'd1; daddr = 18'h00011;
        tick();
        checks++; if (cs_o[1] !== 1'b1 || addr_o[AW +: AW] !== 17'h00008) begin failures++;
            $display("FAIL be_req got=%0b/%0h exp=1/8", cs_o[1], addr_o[AW +: AW]); end
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL be_busy got=%0b exp=1", busy); end
        tick();
        ok_i = 2'b10; data_i = {16'hABCD, 16'h0000};
        #1;
        checks++; if (ok_o !== 2'b00) begin failures++;
            $display("FAIL be_okmask got=%0b exp=00", ok_o); end
        tick();
        checks++; if (view !== 8'hCD || busy !== 1'b1) begin failures++;
            $display("FAIL be_view got=%0h/%0b exp=cd/1", view, busy); end
        ok_i = '0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL be_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_le_slot();
        sel = 3'd0; daddr = 18'h00010;
        tick();
        checks++; if (cs_o[0] !== 1'b1 || addr_o[0 +: AW] !== 17'h00008) begin failures++;
            $display("FAIL le_req got=%0b/%0h exp=1/8", cs_o[0], addr_o[0 +: AW]); end
        cs_i = 2'b10; ok_i = 2'b10; addr_i = {17'h1ABCD, 17'h00000};
        #1;
        checks++; if (cs_o[1] !== 1'b1 || ok_o[1] !== 1'b1 || addr_o[AW +: AW] !== 17'h1ABCD) begin failures++;
            $display("FAIL le_pass1 got=%0b/%0b exp=1/1", cs_o[1], ok_o[1]); end
        tick();
        cs_i = 2'b00; ok_i = 2'b01; data_i = {16'hFFFF, 16'h1234};
        #1;
        checks++; if (cs_o !== 2'b01 || ok_o !== 2'b00) begin failures++;
            $display("FAIL le_pass2 got=%0b/%0b exp=01/00", cs_o, ok_o); end
        tick();
        checks++; if (view !== 8'h34) begin failures++;
            $display("FAIL le_view got=%0h exp=34", view); end
        ok_i = '0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL le_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_pending();
        sel = 3'd1; daddr = 18'h00020;
        tick();
        daddr = 18'h00022; tick();
        daddr = 18'h00024; tick();
        daddr = 18'h00026; tick();
        checks++; if (cs_o[1] !== 1'b1 || addr_o[AW +: AW] !== 17'h00010) begin failures++;
            $display("FAIL pend_first got=%0b/%0h exp=1/10", cs_o[1], addr_o[AW +: AW]); end
        ok_i = 2'b10; data_i = {16'h7788, 16'h0000};
        tick();
        checks++; if (view !== 8'h77 || cs_o[1] !== 1'b0) begin failures++;
            $display("FAIL pend_done got=%0h/%0b exp=77/0", view, cs_o[1]); end
        ok_i = '0;
        tick();
        checks++; if (cs_o[1] !== 1'b1 || addr_o[AW +: AW] !== 17'h00013 || busy !== 1'b1) begin failures++;
            $display("FAIL pend_follow got=%0b/%0h exp=1/13", cs_o[1], addr_o[AW +: AW]); end
        ok_i = 2'b10; data_i = {16'h5566, 16'h0000};
        tick();
        checks++; if (view !== 8'h55) begin failures++;
            $display("FAIL pend_view got=%0h exp=55", view); end
        ok_i = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b0 || cs_o[1] !== 1'b0) begin failures++;
            $display("FAIL pend_once got=%0b/%0b exp=0/0", busy, cs_o[1]); end
    endtask

    task automatic test_timeout();
        int n;
        sel = 3'd0; daddr = 18'h00030;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (cs_o[0] !== 1'b1) break;
            n++;
            tick();
        end
        checks++; if (n != 8) begin failures++;
            $display("FAIL tmo_len got=%0d exp=8", n); end
        checks++; if (view !== 8'hEE || tmo !== 1'b1) begin failures++;
            $display("FAIL tmo_flag got=%0h/%0b exp=ee/1", view, tmo); end
        tick();
        checks++; if (busy !== 1'b0 || tmo !== 1'b1) begin failures++;
            $display("FAIL tmo_sticky got=%0b/%0b exp=0/1", busy, tmo); end
        daddr = 18'h00032;
        tick();
        checks++; if (tmo !== 1'b0 || cs_o[0] !== 1'b1) begin failures++;
            $display("FAIL tmo_clear got=%0b/%0b exp=0/1", tmo, cs_o[0]); end
        ok_i = 2'b01; data_i = {16'h0000, 16'hBEEF};
        tick();
        ok_i = '0;
        tick();
        checks++; if (view !== 8'hEF || busy !== 1'b0) begin failures++;
            $display("FAIL tmo_after got=%0h/%0b exp=ef/0", view, busy); end
    endtask

    task automatic test_enable_drop();
        sel = 3'd1; daddr = 18'h00040;
        tick();
        en = 1'b0;
        daddr = 18'h00044;
        tick();
        ok_i = 2'b10; data_i = {16'h9A9B, 16'h0000};
        tick();
        checks++; if (view !== 8'h9A) begin failures++;
            $display("FAIL en_view got=%0h exp=9a", view); end
        ok_i = '0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL en_idle got=%0b exp=0", busy); end
        tick();
        cs_i = 2'b11; ok_i = 2'b11; addr_i = {17'h12345, 17'h0ABCD};
        #1;
        checks++; if (cs_o !== 2'b11 || ok_o !== 2'b11 || addr_o !== {17'h12345, 17'h0ABCD}) begin failures++;
            $display("FAIL en_pass got=%0b/%0b exp=11/11", cs_o, ok_o); end
        checks++; if (busy !== 1'b0 || view !== 8'h9A) begin failures++;
            $display("FAIL en_hold got=%0b/%0h exp=0/9a", busy, view); end
        cs_i = '0; ok_i = '0; addr_i = '0;
    endtask

    task automatic test_async_reset();
        en = 1'b1; sel = 3'd1; daddr = 18'h00050;
        tick();
        checks++; if (cs_o[1] !== 1'b1 || busy !== 1'b1) begin failures++;
            $display("FAIL ar_req got=%0b/%0b exp=1/1", cs_o[1], busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || view !== 8'h00 || tmo !== 1'b0) begin failures++;
            $display("FAIL ar_regs got=%0b/%0h/%0b exp=0/0/0", busy, view, tmo); end
        checks++; if (cs_o !== cs_i || ok_o !== ok_i) begin failures++;
            $display("FAIL ar_pass got=%0b exp=%0b", cs_o, cs_i); end
        #1;
        rst = 1'b0;
        tick();
        checks++; if (cs_o[1] !== 1'b1 || addr_o[AW +: AW] !== 17'h00028) begin failures++;
            $display("FAIL ar_retrig got=%0b/%0h exp=1/28", cs_o[1], addr_o[AW +: AW]); end
        ok_i = 2'b10; data_i = {16'h1122, 16'h0000};
        tick();
        checks++; if (view !== 8'h11) begin failures++;
            $display("FAIL ar_view got=%0h exp=11", view); end
        ok_i = '0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL ar_idle got=%0b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_be_slot();
        test_le_slot();
        test_pending();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nemesis_rom_peek.md
Name: nemesis_rom_peek

Overview:
- Runtime-switchable SDRAM peek unit, successor to the compile-time single-channel ROM debug pass-through.
- Sits between up to CHANNELS CPU/ROM requesters and their SDRAM slots. In debug mode it hijacks one selected slot, fetches the byte at a debug address and presents it on o_debug_view.
- All other channels, and all channels when debug is off, pass through untouched.

Parameters:
- CHANNELS, 2, number of requester slots (1..8).
- AW, 17, SDRAM word address width per slot (common to all slots).
- DW, 16, SDRAM data width per slot; 8 or 16 only.
- BE_MASK, 2'b10, one bit per slot; 1 = 16-bit big-endian slot (68k style, MSB at even byte address).
- TIMEOUT, 255, cen-cycles to wait for ok before aborting (1..65535).

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  asynchronous, active-high reset
- i_cen  in  1  clock enable; all state advances only when high
- i_enable  in  1  debug mode on
- i_sel  in  3  selected slot index; values >= CHANNELS mean no slot selected
- i_debug_addr  in  AW+1  byte address; bit 0 is the byte lane for DW=16
- i_cs  in  CHANNELS  requester chip selects
- i_addr  in  CHANNELS*AW  requester addresses, slot k at [k*AW +: AW]
- o_cs  out  CHANNELS  SDRAM-side chip selects
- o_addr  out  CHANNELS*AW  SDRAM-side addresses
- i_ok  in  CHANNELS  SDRAM data-valid per slot
- i_data  in  CHANNELS*DW  SDRAM data per slot
- o_ok  out  CHANNELS  ok returned to requesters
- o_debug_view  out  8  last fetched byte
- o_busy  out  1  peek transaction in flight
- o_timeout  out  1  last peek aborted (sticky)

Behaviour:
- Reset (async): o_debug_view=0, o_busy=0, o_timeout=0, state IDLE, pending=0, prev-address/select/enable registers=0. Timeout counter=0.
- Outputs registered: o_debug_view, o_busy, o_timeout. Pass-through paths are combinational.
- Override: slot k is overridden while ovr=1 and k==latched_sel. ovr is set on entry to REQ and cleared on leaving REQ.
  - Overridden slot: o_cs[k]=peek_cs; o_addr = latched byte address >> (DW==16 ? 1 : 0); o_ok[k]=0.
  - All other slots: o_cs=i_cs, o_addr=i_addr, o_ok=i_ok.
- Trigger, sampled on cen: i_enable rising, or (i_enable and (i_debug_addr or i_sel changed vs the previous cen sample)).
- FSM states: IDLE, REQ, DONE.
- IDLE, on trigger with i_sel<CHANNELS:
  - latch sel and address; go REQ next cen.
  - peek_cs=1; counter=0; o_timeout cleared; o_busy=1.
  - A trigger with i_sel>=CHANNELS is ignored.
- REQ:
  - i_ok[sel]=1: latch the byte, peek_cs=0, go DONE.
  - Byte select: DW=8 takes data[7:0]. DW=16 with BE_MASK[sel]=1 takes addr[0] ? [7:0] : [15:8]. BE_MASK[sel]=0 takes addr[0] ? [15:8] : [7:0].
  - counter reaching TIMEOUT: o_debug_view=8'hEE, o_timeout=1, peek_cs=0, go DONE.
- DONE: one cen cycle with ovr=0, to absorb the ok tail. Then:
  - pending=1: clear pending, relatch current addr/sel, go REQ.
  - otherwise: o_busy=0, go IDLE.
- Trigger during REQ/DONE: set pending. A running transaction is never aborted, and only one pending request is kept (the latest address wins).
- i_enable falling during REQ: the transaction completes or times out normally, then the FSM returns to IDLE and pending is cleared. o_debug_view holds its value.
- Latency: a trigger seen at cen n asserts o_cs at cen n+1; ok at cen m updates o_debug_view at cen m+1.
- i_cen low: registers frozen; the override and pass-through muxes stay live.
- TIMEOUT counter width = clog2(TIMEOUT+1); no wrap, it saturates at compare.

Decomposition:
- Package nemesis_peek_pkg: state enum (IDLE, REQ, DONE), TIMEOUT_BYTE=8'hEE, function byte_pick(data, lane, be, dw).
- Sub-module nemesis_peek_mux: purely combinational per-slot override mux, generated CHANNELS times. The FSM stays in the top.

Test Plan:
- DW=16, BE_MASK=2'b10, enable=1, sel=1, addr=18'h00011; slot 1 returns ok with data 16'hABCD two cens after cs -> o_cs[1]=1 with o_addr=17'h00008, o_ok[1]=0 during REQ, o_debug_view=8'hCD, o_busy falls after DONE.
- Same with sel=0 (BE_MASK=0), addr=18'h00010, data 16'h1234 -> o_debug_view=8'h34. Meanwhile slot 1 i_cs/i_ok pass through cycle-exact.
- Address changed three times during REQ -> exactly one follow-up REQ, using the last address; no cs glitch in DONE.
- No ok, TIMEOUT=8 -> o_cs drops after 8 cens, o_debug_view=8'hEE, o_timeout=1; the next trigger clears o_timeout.
- i_enable falls mid-REQ, then ok arrives -> byte latched, FSM returns to IDLE, full pass-through after DONE.
- i_rst pulsed asynchronously mid-REQ (between clock edges) -> all outputs 0 immediately, o_cs equals i_cs, next trigger runs normally.
